// File: rtl/button_pio_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pio_pkg
// Purpose  : Shared register addresses and edge-type encodings for the
//            debounced button PIO.
// Revision : 1.0 - initial release
// ============================================================================
package button_pio_pkg;

  // Avalon-MM word addresses of the register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // True when the debounced bit moved from prev to cur in the selected direction
  function automatic logic edge_hit(input logic cur, input logic prev, input int edge_type);
    logic rise;
    logic fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_RISING:  edge_hit = rise;
      EDGE_FALLING: edge_hit = fall;
      default:      edge_hit = rise | fall;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_pio_edge_if.sv
`default_nettype none
// ============================================================================
// Module   : button_pio_edge_if
// Purpose  : Avalon-MM slave bus plus interrupt line of the button PIO.
// Revision : 1.0 - initial release
// ============================================================================
interface button_pio_edge_if;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  // Host side: issues accesses, receives read data and interrupt
  modport master (
    output address,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  // PIO side: decodes accesses, returns read data and interrupt
  modport slave (
    input  address,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/button_pio_edge_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pio_debounce
// Purpose  : Single-bit 2-flop synchroniser followed by a stable-count
//            debouncer; exposes both the synchronised and debounced value.
// Revision : 1.0 - initial release
// ============================================================================
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic async_in,
  output logic      sync_out,
  output logic      deb_out
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic [c_CNT_W-1:0] r_cnt;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatch cycles; accept the new level once it has held long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == c_CNT_MAX) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign sync_out = r_sync2;
  assign deb_out  = r_deb;

endmodule
`default_nettype wire

// File: rtl/button_pio_edge.sv
`default_nettype none
// ============================================================================
// Module   : button_pio_edge
// Purpose  : Debounced button PIO with edge capture, interrupt mask and an
//            Avalon-MM register interface (1-cycle registered reads).
// Revision : 1.0 - initial release
// ============================================================================
module button_pio_edge
  import button_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISING
) (
  input  wire logic             clk,
  input  wire logic             reset,
  button_pio_edge_if.slave      bus,
  input  wire logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_deb_q;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  // Only the low WIDTH write-data bits carry register content
  assign w_unused_wdata = ^bus.writedata;

  // One synchroniser/debouncer and edge detector per input bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .async_in (in_port[i]),
      .sync_out (w_sync[i]),
      .deb_out  (w_deb[i])
    );
    assign w_event[i] = edge_hit(w_deb[i], r_deb_q[i], EDGE_TYPE);
  end

  assign w_wr_mask = ~bus.write_n && (bus.address == ADDR_MASK);
  assign w_wr_edge = ~bus.write_n && (bus.address == ADDR_EDGE);
  assign w_clr     = w_wr_edge ? bus.writedata[WIDTH-1:0] : '0;

  // Read mux, zero-extended to the 32-bit bus
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux = 32'(w_deb);
      ADDR_MASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge);
      default:   w_rd_mux = 32'(w_sync);
    endcase
  end

  // Delayed debounced value for edge detection
  always_ff @(posedge clk) begin
    if (reset) r_deb_q <= '0;
    else       r_deb_q <= w_deb;
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)          r_mask <= '0;
    else if (w_wr_mask) r_mask <= bus.writedata[WIDTH-1:0];
  end

  // Edge capture: write-1-to-clear, a simultaneous new edge wins over the clear
  always_ff @(posedge clk) begin
    if (reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_clr) | w_event;
  end

  // Registered read data and level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      bus.readdata <= w_rd_mux;
      bus.irq      <= |(r_edge & r_mask);
    end
  end

endmodule
`default_nettype wire

// File: doc/button_pio_edge.md
BUTTON_PIO_EDGE -- requirements
Module: button_pio_edge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of input bits (range 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the consecutive stable cycles required to accept a change (range 2..2^20).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, meaning the edge that sets capture: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the synchronous, active-high reset.
REQ-006 The block SHALL have port address, input, 2 bits: the Avalon-MM word address.
REQ-007 The block SHALL have port write_n, input, 1 bit: the active-low write strobe.
REQ-008 The block SHALL have port writedata, input, 32 bits: the write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: the registered read data.
REQ-010 The block SHALL have port in_port, input, WIDTH bits: the asynchronous button inputs.
REQ-011 The block SHALL have port irq, output, 1 bit: the level interrupt request.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchroniser; the synchronised value is s.
REQ-013 Per bit, while s != debounced value d, a counter SHALL increment every cycle.
REQ-014 When that counter equals DEBOUNCE_CYCLES-1 and s != d still holds, d SHALL take s and the counter SHALL clear.
REQ-015 Any cycle with s == d SHALL clear the counter, so glitches shorter than DEBOUNCE_CYCLES cycles are discarded.
REQ-016 The edge_capture[i] bit SHALL set in the cycle after d[i] changes in the direction selected by EDGE_TYPE.
REQ-017 Register map:
- 0: data = d (read-only)
- 1: irq_mask (read/write, bits WIDTH-1:0)
- 2: edge_capture (write-1-to-clear)
- 3: raw = s (read-only)
REQ-018 Unused readdata bits (31:WIDTH) SHALL read as 0.
REQ-019 readdata SHALL be registered every cycle from the mux on address, giving 1-cycle read latency; no wait states and no read strobe.
REQ-020 A write (write_n=0) to address 1 SHALL load irq_mask from writedata[WIDTH-1:0]; writes to addresses 0 and 3 SHALL be ignored.
REQ-021 A write to address 2 SHALL clear each edge_capture bit whose writedata bit is 1.
REQ-022 If a new edge and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-023 irq SHALL be registered as the OR of (edge_capture & irq_mask), valid one cycle after either operand changes.
REQ-024 The irq_mask update and the irq recomputation SHALL take effect for irq in the cycle after the write.

Reset
REQ-025 While reset=1 at a clk edge, the following SHALL be cleared: synchroniser flops, d, counters, irq_mask, edge_capture, readdata (0) and irq (0).
REQ-026 An in-progress debounce count SHALL be discarded on reset.
REQ-027 After reset, a button already held high SHALL be accepted after 2 + DEBOUNCE_CYCLES cycles and SHALL produce a rising edge capture.

Structure
REQ-028 A shared package button_pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_RAW=3) and the EDGE_TYPE encodings.
REQ-029 A single-bit sub-module pio_debounce (synchroniser plus counter, producing d) SHALL be instantiated WIDTH times with a generate loop.
REQ-030 The counter width SHALL be $clog2(DEBOUNCE_CYCLES).

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated)
REQ-031 Scenario 1: after reset, read addresses 0-3 -> readdata=0 one cycle after each address; irq=0.
REQ-032 Scenario 2: in_port[1] goes 0->1 and holds -> data reads 0x2 from cycle 6 onward; edge_capture reads 0x2.
REQ-033 Scenario 3: 3-cycle pulse on in_port[0] -> data and edge_capture remain 0.
REQ-034 Scenario 4: mask=0x2, then an edge on bit 1 -> irq=1; write 0x2 to address 2 -> irq=0 two cycles later.
REQ-035 Scenario 5: the clear write coincides with a new bit-1 edge -> edge_capture bit 1 stays 1 and irq stays 1.
REQ-036 Scenario 6: EDGE_TYPE=1, in_port[2] goes 1->0 after settling high -> edge_capture=0x4 only on the falling edge; reset mid-count -> no capture and data=0.
